// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit between execute stage and data-memory bus.
// One valid/ready transaction per memory instruction; stalls the core while
// the transaction is outstanding and returns aligned, extended load data.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses (no bus request, one-cycle misalign_err pulse).
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic              load_ram_enable,
  input  logic [2:0]        load_ram_flag,
  input  logic [1:0]        write_ram_flag,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;

  state_e            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  size_e             size_q;
  logic              sign_q;
  logic [1:0]        off_q;
  logic [31:0]       load_data_q;
  logic              mis_q;

  logic              start;
  size_e             dec_size;
  logic              dec_sign;
  logic [3:0]        dec_wstrb;
  logic [31:0]       dec_wdata;
  logic              misaligned;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [31:0]       ext_data;

  // Decode the memory controls into access size, sign and store lanes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    start     = load_ram_enable || (write_ram_flag != 2'b00);
    dec_size  = SZ_W;
    dec_sign  = 1'b0;
    dec_wstrb = 4'b0000;
    dec_wdata = store_data;
    if (load_ram_enable) begin
      // A load takes priority over a simultaneous store; unknown flags act as lw.
      case (load_ram_flag)
        3'b110:  begin dec_size = SZ_H; dec_sign = 1'b1; end
        3'b111:  begin dec_size = SZ_B; dec_sign = 1'b1; end
        3'b011:  dec_size = SZ_B;
        3'b010:  dec_size = SZ_H;
        default: dec_size = SZ_W;
      endcase
    end else begin
      case (write_ram_flag)
        2'b01: dec_wstrb = 4'b1111;
        2'b10: begin
          dec_size  = SZ_H;
          dec_wstrb = addr[1] ? 4'b1100 : 4'b0011;
          dec_wdata = {2{store_data[15:0]}};
        end
        2'b11: begin
          dec_size  = SZ_B;
          dec_wstrb = 4'b0001 << addr[1:0];
          dec_wdata = {4{store_data[7:0]}};
        end
        default: dec_wstrb = 4'b0000;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((dec_size == SZ_H) && addr[0]) ||
                      ((dec_size == SZ_W) && (addr[1:0] != 2'b00));
`else
  // Offending low bits are simply ignored: the bus address is word aligned
  // and half lanes depend on addr[1] only.
  assign misaligned = 1'b0;
`endif

  // Extract the addressed byte/half from the read word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    sel_b = mem_rdata[7:0];
      2'd1:    sel_b = mem_rdata[15:8];
      2'd2:    sel_b = mem_rdata[23:16];
      default: sel_b = mem_rdata[31:24];
    endcase
    sel_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    ext_data = {{24{sign_q & sel_b[7]}}, sel_b};
      SZ_H:    ext_data = {{16{sign_q & sel_h[15]}}, sel_h};
      default: ext_data = mem_rdata;
    endcase
  end

  // Next-state logic and the combinational stall toward the core.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, request latch and load-result register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      size_q      <= SZ_W;
      sign_q      <= 1'b0;
      off_q       <= '0;
      load_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= 1'b0;
      if ((state_q == IDLE) && start) begin
        if (misaligned) begin
          mis_q <= 1'b1;
          if (load_ram_enable) load_data_q <= '0;
        end else begin
          we_q    <= !load_ram_enable;
          addr_q  <= {addr[ADDR_W-1:2], 2'b00};
          wdata_q <= dec_wdata;
          wstrb_q <= dec_wstrb;
          size_q  <= dec_size;
          sign_q  <= dec_sign;
          off_q   <= addr[1:0];
        end
      end
      if ((state_q == REQ) && mem_ready && !we_q) load_data_q <= ext_data;
    end
  end

  assign mem_valid    = (state_q == REQ);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign load_data    = load_data_q;
  assign misalign_err = mis_q;

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit between the execute stage and the data-memory bus of the single-cycle RV32I core. It consumes the decoder's memory controls (`load_ram_enable`, `load_ram_flag`, `write_ram_flag`), the ALU-computed address and rs2 data. It runs one valid/ready bus transaction per memory instruction and stalls the core while the transaction is outstanding. Load data is returned byte/half-aligned and sign- or zero-extended, ready for register write-back.

## Interface
- ADDR_W, 32, byte-address width of `mem_addr` and `addr`
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset; synchronous, active-low; sampled on rising edge of `clk`
- addr  in  ADDR_W  effective address (ALU result)
- store_data  in  32  rs2 value
- load_ram_enable  in  1  instruction is a load
- load_ram_flag  in  3  001 lw, 110 lh, 111 lb, 011 lbu, 010 lhu
- write_ram_flag  in  2  00 none, 01 sw, 10 sh, 11 sb
- stall  out  1  hold PC/regfile write; combinational
- load_data  out  32  extended load result, registered
- misalign_err  out  1  one-cycle misalignment pulse, registered
- mem_valid  out  1  bus request valid
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned bus address (bits [1:0] = 00)
- mem_wdata  out  32  lane-replicated write data
- mem_wstrb  out  4  byte enables, writes only; 0000 on reads
- mem_ready  in  1  bus accepts (write) / returns `mem_rdata` (read)
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, DONE.
- Start condition, IDLE only: `load_ram_enable` OR `write_ram_flag != 00`.
  - If both are set, the load wins and the store is ignored.
  - `load_ram_enable` with an undefined flag value is treated as lw.
- IDLE with start condition:
  - Latch we, word address, wdata, wstrb, access size, sign and addr[1:0].
  - Next state: REQ.
- REQ:
  - `mem_valid` = 1; all bus outputs are held stable.
  - On `mem_valid && mem_ready`, capture `mem_rdata` if a load; next state: DONE.
- DONE:
  - Lasts exactly one cycle; no new start is accepted.
  - `load_data` is updated on entry and holds until the next load completes.
  - Next state: IDLE.
- Store lanes:
  - sw: wstrb 1111, wdata = rs2.
  - sh: wstrb = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - sb: wstrb = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
- Load extraction:
  - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- `stall` = (IDLE && start) || REQ. It is low in DONE, so the core retires the instruction at the end of DONE.
- `mem_ready` outside REQ is ignored.

## Timing
- Reset (after the edge sampling `rst_n` = 0): state IDLE; `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `load_data`, `misalign_err` all 0. `stall` = 0 unless the start condition is present.
- Minimum latency, start in cycle T:
  - REQ in T+1; if `mem_ready` = 1 in T+1, DONE in T+2.
  - `stall` is high in T and T+1.
  - `load_data` is valid in T+2.
- Every wait cycle of `mem_ready` = 0 adds one stall cycle. There is no timeout.
- Reset asserted in REQ abandons the transaction. `mem_valid` is 0 from the next cycle and no DONE occurs.
- Back-to-back memory instructions: the next start is seen in the IDLE cycle following DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are lh/lhu/sh with addr[0] = 1, and lw/sw with addr[1:0] != 00.
  - These go IDLE -> DONE directly with no bus request.
  - `misalign_err` = 1 in DONE; a load returns `load_data` = 0; a store writes nothing.
  - `stall` is high for one cycle only.
- Not defined:
  - `misalign_err` is tied to 0.
  - Offending low address bits are ignored: word accesses use addr[1:0] = 00 and half accesses use addr[1] only.
  - The access proceeds normally.

## Test plan
- sw addr 0x100, rs2 0xDEADBEEF, `mem_ready` immediate -> REQ with addr 0x100, wstrb 1111, wdata 0xDEADBEEF, we = 1; `stall` high 2 cycles.
- sb addr 0x103, rs2 0x000000A5 -> wstrb 1000, wdata 0xA5A5A5A5.
- lb addr 0x102, `mem_rdata` 0x12F03456 -> `load_data` 0xFFFFFFF0; lbu at the same address -> 0x000000F0.
- lh addr 0x202, `mem_ready` low 3 cycles then high, `mem_rdata` 0x8001_0000 -> `stall` high 5 cycles, `load_data` 0xFFFF8001.
- Reset pulsed in REQ of lw -> `mem_valid` 0 next cycle, `load_data` 0, FSM IDLE; a new lw then completes normally.
- lw addr 0x101 -> with `LSU_MISALIGN_TRAP_EN`: no `mem_valid`, `misalign_err` pulse, `load_data` 0; without it: `mem_addr` 0x100, normal read.
